// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Purpose  : Shared types and constants for the commit-trace emitter and
//             the receiver-side checker that consumes the same record format.
//  Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

  // Emitter FSM: waiting for a commit, or streaming a record.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Word tags within one record.
  localparam logic [5:0] TAG_PC   = 6'd0;
  localparam logic [5:0] TAG_INST = 6'd1;
  localparam logic [5:0] TAG_REG0 = 6'd2;

  localparam int NUM_REGS_DEF = 32;
  localparam int REC_WORDS    = NUM_REGS_DEF + 2;

  // Tag carried by the final word of a record.
  function automatic logic [5:0] last_tag(input int num_regs);
    return 6'(num_regs + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_word_mux.sv
`default_nettype none
// ============================================================================
//  Module   : trace_word_mux
//  Purpose  : Selects record word n: pc, instruction, or regfile data.
//             Regfile register 0 always reads as zero regardless of the
//             debug port, matching the architectural hardwired zero.
//  Revision : 1.0  initial release
// ============================================================================
module trace_word_mux
  import trace_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        i_sel,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_inst,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic [DATA_W-1:0] o_word,
  output logic [4:0]        o_rf_raddr
);

  // Word select; the regfile address is only non-zero for register words.
  always_comb begin
    o_word     = '0;
    o_rf_raddr = '0;
    if (i_sel == TAG_PC) begin
      o_word = i_pc;
    end else if (i_sel == TAG_INST) begin
      o_word = i_inst;
    end else begin
      o_rf_raddr = 5'(i_sel - TAG_REG0);
      if (i_sel != TAG_REG0) begin
        o_word = i_rf_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/commit_trace_tx.sv
`default_nettype none
// ============================================================================
//  Module   : commit_trace_tx
//  Purpose  : Streams a per-commit trace record (pc, instr, regfile0..N-1)
//             over a valid/ready link while holding the core via busy so
//             the register snapshot stays coherent.
//  Revision : 1.0  initial release
// ============================================================================
module commit_trace_tx
  import trace_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              commit,
  input  logic [DATA_W-1:0] commit_pc,
  input  logic [DATA_W-1:0] commit_inst,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [5:0]        tx_tag,
  output logic              tx_last,
  output logic              overflow,
  output logic [CNT_W-1:0]  rec_cnt
);

  localparam logic [5:0] c_LAST_TAG = last_tag(NUM_REGS);

  state_t              r_state;
  logic [5:0]          r_idx;
  logic [DATA_W-1:0]   r_inst_hold;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_last;
  logic                r_busy;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_rec_cnt;

  logic                w_hs;
  logic                w_load;
  logic [5:0]          w_next_idx;
  logic [5:0]          w_sel;
  logic [DATA_W-1:0]   w_word;

  assign w_hs       = r_valid && tx_ready;
  assign w_next_idx = r_idx + 6'd1;
  // A load cycle fetches the next word of the current record.
  assign w_load     = (r_state == SEND) && w_hs && (r_idx < c_LAST_TAG);
  // Outside a load cycle the select parks at tag 0 so rf_raddr reads 0.
  assign w_sel      = w_load ? w_next_idx : TAG_PC;

  trace_word_mux #(
    .DATA_W (DATA_W)
  ) u_word_mux (
    .i_sel      (w_sel),
    .i_pc       (commit_pc),
    .i_inst     (r_inst_hold),
    .i_rf_rdata (rf_rdata),
    .o_word     (w_word),
    .o_rf_raddr (rf_raddr)
  );

  // Record FSM with registered stream outputs, busy, overflow and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_inst_hold <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_rec_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (commit && trace_en) begin
            r_state     <= SEND;
            r_idx       <= TAG_PC;
            r_data      <= commit_pc;
            r_inst_hold <= commit_inst;
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_last      <= 1'b0;
          end
        end
        SEND: begin
          // Core must not commit during a record; flag it and keep going.
          if (commit && trace_en) begin
            r_overflow <= 1'b1;
          end
          if (w_hs) begin
            if (r_idx == c_LAST_TAG) begin
              r_state   <= IDLE;
              r_valid   <= 1'b0;
              r_busy    <= 1'b0;
              r_last    <= 1'b0;
              r_rec_cnt <= r_rec_cnt + 1'b1;
            end else begin
              r_idx  <= w_next_idx;
              r_data <= w_word;
              r_last <= (w_next_idx == c_LAST_TAG);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign tx_valid = r_valid;
  assign tx_data  = r_data;
  assign tx_tag   = r_idx;
  assign tx_last  = r_last;
  assign overflow = r_overflow;
  assign rec_cnt  = r_rec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_trace_tx
//  Purpose  : Self-checking bench for commit_trace_tx. Expected record words
//             are pushed to a queue at commit time and popped on handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_commit_trace_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        commit;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [5:0]  tx_tag;
  logic        tx_last;
  logic        overflow;
  logic [31:0] rec_cnt;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  commit_trace_tx #(
    .NUM_REGS (32),
    .DATA_W   (32),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .commit      (commit),
    .commit_pc   (commit_pc),
    .commit_inst (commit_inst),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .busy        (busy),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_tag      (tx_tag),
    .tx_last     (tx_last),
    .overflow    (overflow),
    .rec_cnt     (rec_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  tag;
    logic        last;
  } exp_t;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rf0;
    int          duty;
    logic        exp_start;
    logic [31:0] exp_rec;
  } vec_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          duty   = 100;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [5:0]  prev_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got timeout expected event", name);
  endtask

  // Expected words for a record from the bench's own regfile image.
  task automatic push_record(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    for (int n = 0; n < trace_pkg::REC_WORDS; n++) begin
      e.tag  = 6'(n);
      e.last = (n == trace_pkg::REC_WORDS - 1);
      if (n == 0)      e.data = pc;
      else if (n == 1) e.data = inst;
      else if (n == 2) e.data = 32'h0;
      else             e.data = rf[n-2];
      q.push_back(e);
    end
  endtask

  task automatic do_commit(input logic en, input logic [31:0] pc, input logic [31:0] inst);
    @(posedge clk); #1;
    trace_en    = en;
    commit      = 1'b1;
    commit_pc   = pc;
    commit_inst = inst;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now(name);
  endtask

  task automatic wait_tag(input logic [5:0] tag, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(tx_valid && tx_tag == tag) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now(name);
  endtask

  // Random sink readiness at the configured duty.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 99) < duty);
    end
  end

  // Monitor: stability under stall, and scoreboard compare on handshake.
  always @(negedge clk) begin
    if (reset && tx_valid) begin
      if (prev_stall) begin
        chk("stall_data", tx_data, prev_data);
        chk("stall_tag", 32'(tx_tag), 32'(prev_tag));
      end
      if (tx_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got tag %0d data 0x%08h expected no word", tx_tag, tx_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_data", tx_data, e.data);
          chk("word_tag", 32'(tx_tag), 32'(e.tag));
          chk("word_last", 32'(tx_last), 32'(e.last));
        end
      end
    end
    prev_stall = reset && tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_tag   = tx_tag;
  end

  vec_t vecs[4];

  initial begin
    int n;
    logic [31:0] exp_rec;

    vecs[0] = '{1'b1, 32'h00400004, 32'h3c010000, 32'h0,        100, 1'b1, 32'd1};
    vecs[1] = '{1'b1, 32'h00400010, 32'h8c220004, 32'h0,         30, 1'b1, 32'd2};
    vecs[2] = '{1'b0, 32'h00400020, 32'h00000000, 32'h0,        100, 1'b0, 32'd2};
    vecs[3] = '{1'b1, 32'h00400024, 32'hac230008, 32'hdeadbeef,  60, 1'b1, 32'd3};

    for (int k = 0; k < 32; k++) rf[k] = 32'h1000 + 32'(k);
    rf[0]       = 32'h0;
    reset       = 1'b0;
    trace_en    = 1'b0;
    commit      = 1'b0;
    commit_pc   = '0;
    commit_inst = '0;

    #23;
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", tx_data, 0);
    chk("rst_tag", 32'(tx_tag), 0);
    chk("rst_last", 32'(tx_last), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_rec_cnt", rec_cnt, 0);
    chk("rst_raddr", 32'(rf_raddr), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven records.
    for (int i = 0; i < 4; i++) begin
      duty  = vecs[i].duty;
      rf[0] = vecs[i].rf0;
      if (vecs[i].exp_start) push_record(vecs[i].pc, vecs[i].inst);
      do_commit(vecs[i].en, vecs[i].pc, vecs[i].inst);
      if (vecs[i].exp_start) begin
        wait_done("record_done");
      end else begin
        repeat (3) @(negedge clk);
        chk("dis_valid", 32'(tx_valid), 0);
        chk("dis_busy", 32'(busy), 0);
      end
      chk("tbl_rec_cnt", rec_cnt, vecs[i].exp_rec);
      chk("tbl_overflow", 32'(overflow), 0);
    end
    rf[0] = 32'h0;
    duty  = 100;
    exp_rec = 32'd3;

    // Busy spans exactly one record at full rate.
    push_record(32'h00400040, 32'h24020001);
    do_commit(1'b1, 32'h00400040, 32'h24020001);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", 32'(n), 32'd34);
    wait_done("busy_done");
    exp_rec++;
    chk("busy_rec_cnt", rec_cnt, exp_rec);

    // Commits while busy are dropped and flagged.
    push_record(32'h00400004, 32'h3c010000);
    do_commit(1'b1, 32'h00400004, 32'h3c010000);
    wait_tag(6'd5, "ovf_tag5");
    commit    = 1'b1;
    commit_pc = 32'h00400008;
    @(posedge clk); #1;
    commit = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    n = 0;
    @(negedge clk);
    while (!(tx_valid && tx_last && tx_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("ovf_last");
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    exp_rec++;
    repeat (3) @(negedge clk);
    chk("ovf_valid_low", 32'(tx_valid), 0);
    chk("ovf_busy_low", 32'(busy), 0);
    chk("ovf_rec_cnt", rec_cnt, exp_rec);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_queue", 32'(q.size()), 0);
    push_record(32'h0040000c, 32'h00000020);
    do_commit(1'b1, 32'h0040000c, 32'h00000020);
    wait_done("ovf_next_done");
    exp_rec++;
    chk("ovf_next_rec_cnt", rec_cnt, exp_rec);
    chk("ovf_still", 32'(overflow), 1);

    // Asynchronous reset in the middle of a record.
    duty = 70;
    push_record(32'h00400100, 32'h8fbf0010);
    do_commit(1'b1, 32'h00400100, 32'h8fbf0010);
    wait_tag(6'd17, "ar_tag17");
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    chk("ar_valid", 32'(tx_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_data", tx_data, 0);
    chk("ar_tag", 32'(tx_tag), 0);
    chk("ar_last", 32'(tx_last), 0);
    chk("ar_overflow", 32'(overflow), 0);
    chk("ar_rec_cnt", rec_cnt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_record(32'h00400200, 32'h03e00008);
    do_commit(1'b1, 32'h00400200, 32'h03e00008);
    chk("ar_restart_cnt", rec_cnt, 0);
    wait_done("ar_done");
    chk("ar_after_cnt", rec_cnt, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_trace_tx.md
Name: commit_trace_tx

Overview:
- Hardware emitter for the per-instruction commit trace: pc, instr, then regfile0..regfile31.
- Word order matches the simulation dump the team uses for golden-model comparison.
- Sits beside the multicycle CPU core. On each commit pulse it streams a 34-word record over a valid/ready interface to a UART/FIFO/host link.
- Holds the core stalled via busy so the register snapshot is coherent.

Parameters:
- NUM_REGS, 32, architectural registers dumped per record; record length is NUM_REGS+2.
- DATA_W, 32, word width of pc, instr, register data and tx_data.
- CNT_W, 32, width of the retired-record counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- trace_en  in  1  commit pulses are ignored while 0.
- commit  in  1  one-cycle pulse: instruction retired, PC changed.
- commit_pc  in  DATA_W  PC of the retired instruction, valid with commit.
- commit_inst  in  DATA_W  encoding of the retired instruction, valid with commit.
- rf_raddr  out  5  regfile debug read address.
- rf_rdata  in  DATA_W  regfile debug read data; combinational, same cycle.
- busy  out  1  record in flight; core must not commit or write regfile.
- tx_valid  out  1  stream word valid.
- tx_ready  in  1  sink accepts word.
- tx_data  out  DATA_W  stream word.
- tx_tag  out  6  word index: 0=pc, 1=instr, 2+k=regfile k.
- tx_last  out  1  high on the final word (tag NUM_REGS+1).
- overflow  out  1  sticky: commit arrived while busy.
- rec_cnt  out  CNT_W  number of fully transferred records.

Behaviour:
- Reset (async, reset==0) forces every output and register to 0: state IDLE, tx_valid=0, tx_data=0, tx_tag=0, tx_last=0, busy=0, overflow=0, rec_cnt=0, idx=0.
- Reset mid-record abandons the record. Nothing resumes and rec_cnt is not incremented.
- FSM has two states, IDLE and SEND.
- IDLE:
  - commit && trace_en: next edge goes to SEND with tx_data<=commit_pc, tx_tag<=0, tx_valid<=1, busy<=1, idx<=0, and commit_inst latched into inst_hold.
  - commit && !trace_en: no effect.
- SEND:
  - tx_data, tx_tag and tx_last hold stable while tx_valid && !tx_ready.
  - On handshake (tx_valid && tx_ready) with idx<NUM_REGS+1: idx<=idx+1 and tx_data<=word(idx+1), so words go back-to-back. Minimum record time is 34 cycles.
  - word(1)=inst_hold.
  - word(n) for n>=2 is rf_rdata with rf_raddr=n-2 driven combinationally during the load cycle.
  - word(2) is forced to 0 (regfile0), independent of rf_rdata.
  - rf_raddr=0 whenever not loading a register word.
  - On handshake with idx==NUM_REGS+1: tx_valid<=0, busy<=0, tx_last<=0, rec_cnt<=rec_cnt+1 (wraps at 2^CNT_W), return to IDLE.
  - A commit in the same cycle as this final handshake counts as arriving while busy.
- tx_last = tx_valid && (tx_tag==NUM_REGS+1), registered together with tx_tag.
- Commit while busy (SEND): the commit is dropped, overflow<=1 (sticky until reset), and the current record continues unaffected.
- busy is a registered output, high for every cycle in SEND including the cycle tx_last is presented.
- tx_valid never drops without a handshake, except on reset.

Decomposition:
- Shared package trace_pkg holds:
  - state enum {IDLE, SEND};
  - TAG_PC=0, TAG_INST=1, TAG_REG0=2;
  - REC_WORDS=NUM_REGS+2.
- No sub-module needed. One optional sub-module, trace_word_mux, provides the combinational word(n) select (pc/inst/regfile with regfile0 forced to 0). It is reused by a later receiver-side checker.

Test Plan:
- Single record:
  - Stimulus: reg k preloaded to 0x1000+k; commit pc=0x00400004, inst=0x3c010000; tx_ready held 1.
  - Response: 34 consecutive words 0x00400004, 0x3c010000, 0x0, 0x1001..0x101f.
  - tx_last only on tag 33; busy high 34 cycles; rec_cnt=1.
- Backpressure:
  - Stimulus: tx_ready random 30% duty.
  - Response: tx_data/tx_tag stable while stalled; same 34 words in order; no duplicates or losses.
- Overflow:
  - Stimulus: second commit pc=0x00400008 at tag 5, then another on the final-handshake cycle.
  - Response: both dropped; overflow=1 sticky; rec_cnt=1; next commit after busy falls streams normally.
- trace_en=0:
  - Stimulus: commit pulse with trace_en=0.
  - Response: tx_valid stays 0, busy 0, overflow 0, rec_cnt unchanged.
- Async reset mid-record:
  - Stimulus: reset=0 at tag 17, asynchronous to clk.
  - Response: all outputs 0 immediately; after release, a new commit starts at tag 0 with rec_cnt=0.
- Regfile0 masking:
  - Stimulus: rf_rdata forced 0xdeadbeef for address 0.
  - Response: tag 2 word is 0x00000000.
